pin_entry_ctrl: RTL and testbench

Sequential controller for PIN entry and verification on the cold-wallet two-button interface. It synchronizes the left (confirm) and right (increment) buttons and steps a digit selector. It assembles DIGITS BCD digits and, on first use, stores them as the device PIN. On later entries it compares them against the stored PIN, drives the unlock flag, counts failed attempts and enforces a timed lockout.

---
 rtl/pin_entry_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_ctrl.sv
// PIN entry/verification controller for a two-button wallet interface.
// Buttons are synchronized and edge-detected, digits are assembled, stored or checked, and lockout is timed.
module pin_entry_ctrl #(
    parameter  int DIGITS      = 4,
    parameter  int MAX_TRIES   = 3,
    parameter  int LOCK_CYCLES = 1000,
    localparam int IDX_W       = $clog2(DIGITS + 1),
    localparam int FAIL_W      = $clog2(MAX_TRIES + 1),
    localparam int TMR_W       = $clog2(LOCK_CYCLES + 1),
    localparam int PIN_W       = 4 * DIGITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              b_esq_i,
    input  logic              b_dir_i,
    input  logic              lock_i,
    output logic [3:0]        digit_o,
    output logic [IDX_W-1:0]  digit_idx_o,
    output logic              pin_set_o,
    output logic              w_o,
    output logic              locked_o,
    output logic [FAIL_W-1:0] fail_cnt_o
);

    // state    | meaning
    // SETUP    | first use, digits are collected into the stored PIN
    // ENTER    | digits are collected for comparison
    // CHECK    | one-cycle compare of entry buffer against stored PIN
    // UNLOCKED | access granted until lock_i
    // LOCKOUT  | too many failures, buttons ignored until timer expires
    typedef enum logic [2:0] {
        S_SETUP,
        S_ENTER,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        esq_pipe_q, esq_pipe_d;
    logic [2:0]        dir_pipe_q, dir_pipe_d;
    logic [3:0]        digit_q, digit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PIN_W-1:0]  entry_q, entry_d;
    logic [PIN_W-1:0]  pin_q, pin_d;
    logic              pin_set_q, pin_set_d;
    logic              w_q, w_d;
    logic              locked_q, locked_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic esq_ev;
    logic dir_ev;

    // pipe[0..1] form the synchronizer, pipe[2] holds the previous synced level
    assign esq_pipe_d = {esq_pipe_q[1:0], b_esq_i};
    assign dir_pipe_d = {dir_pipe_q[1:0], b_dir_i};
    assign esq_ev     = esq_pipe_q[1] & ~esq_pipe_q[2] & ~(dir_pipe_q[1] & ~dir_pipe_q[2]);
    assign dir_ev     = dir_pipe_q[1] & ~dir_pipe_q[2] & ~(esq_pipe_q[1] & ~esq_pipe_q[2]);

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        idx_d     = idx_q;
        entry_d   = entry_q;
        pin_d     = pin_q;
        pin_set_d = pin_set_q;
        w_d       = w_q;
        locked_d  = locked_q;
        fail_d    = fail_q;
        timer_d   = timer_q;

        case (state_q)
            S_SETUP, S_ENTER: begin
                if (dir_ev) begin
                    digit_d = (digit_q == 4'd9) ? 4'd0 : 4'(digit_q + 4'd1);
                end
                if (esq_ev) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            entry_d[i*4 +: 4] = digit_q;
                        end
                    end
                    digit_d = 4'd0;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d = '0;
                        if (state_q == S_SETUP) begin
                            pin_d     = entry_d;
                            pin_set_d = 1'b1;
                            entry_d   = '0;
                            state_d   = S_ENTER;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        idx_d = IDX_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            S_CHECK: begin
                entry_d = '0;
                if (entry_q == pin_q) begin
                    w_d     = 1'b1;
                    fail_d  = '0;
                    state_d = S_UNLOCKED;
                end else begin
                    fail_d = FAIL_W'(fail_q + FAIL_W'(1));
                    if (fail_q == FAIL_W'(MAX_TRIES - 1)) begin
                        timer_d  = TMR_W'(LOCK_CYCLES - 1);
                        locked_d = 1'b1;
                        state_d  = S_LOCKOUT;
                    end else begin
                        state_d = S_ENTER;
                    end
                end
            end
            S_UNLOCKED: begin
                if (lock_i) begin
                    w_d     = 1'b0;
                    state_d = S_ENTER;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    locked_d = 1'b0;
                    fail_d   = '0;
                    state_d  = S_ENTER;
                end else begin
                    timer_d = TMR_W'(timer_q - TMR_W'(1));
                end
            end
            default: begin
                state_d = S_SETUP;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_SETUP;
            esq_pipe_q <= '0;
            dir_pipe_q <= '0;
            digit_q    <= '0;
            idx_q      <= '0;
            entry_q    <= '0;
            pin_q      <= '0;
            pin_set_q  <= 1'b0;
            w_q        <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            esq_pipe_q <= esq_pipe_d;
            dir_pipe_q <= dir_pipe_d;
            digit_q    <= digit_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            pin_q      <= pin_d;
            pin_set_q  <= pin_set_d;
            w_q        <= w_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
        end
    end

    assign digit_o     = digit_q;
    assign digit_idx_o = idx_q;
    assign pin_set_o   = pin_set_q;
    assign w_o         = w_q;
    assign locked_o    = locked_q;
    assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed plan scenarios plus random button traffic,
// compared every cycle against a digit-array model of the PIN entry rules.
module tb_pin_entry_ctrl;
    localparam int DIGITS      = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 1000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       b_esq_i = 1'b0;
    logic       b_dir_i = 1'b0;
    logic       lock_i = 1'b0;
    logic [3:0] digit_o;
    logic [2:0] digit_idx_o;
    logic       pin_set_o;
    logic       w_o;
    logic       locked_o;
    logic [1:0] fail_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    pin_entry_ctrl #(
        .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .b_esq_i(b_esq_i), .b_dir_i(b_dir_i),
        .lock_i(lock_i), .digit_o(digit_o), .digit_idx_o(digit_idx_o),
        .pin_set_o(pin_set_o), .w_o(w_o), .locked_o(locked_o), .fail_cnt_o(fail_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes as small ints, digits as int arrays,
    // button history as the levels sampled on the previous three edges.
    localparam int M_SETUP = 0, M_ENTER = 1, M_CHECK = 2, M_OPEN = 3, M_LOCK = 4;
    int  m_mode, m_digit, m_cnt, m_fails, m_left;
    int  m_entry [DIGITS];
    int  m_pin   [DIGITS];
    bit  m_pin_set, m_w, m_locked, m_valid = 0;
    bit  esq_h [3];
    bit  dir_h [3];

    always @(posedge clk_i) begin
        bit e_ev, d_ev, same;
        if (rst_i) begin
            m_mode = M_SETUP; m_digit = 0; m_cnt = 0; m_fails = 0; m_left = 0;
            m_pin_set = 0; m_w = 0; m_locked = 0; m_valid = 1;
            for (int i = 0; i < DIGITS; i++) begin m_entry[i] = 0; m_pin[i] = 0; end
            for (int i = 0; i < 3; i++) begin esq_h[i] = 0; dir_h[i] = 0; end
        end else if (m_valid) begin
            e_ev = esq_h[1] && !esq_h[2];
            d_ev = dir_h[1] && !dir_h[2];
            if (e_ev && d_ev) begin e_ev = 0; d_ev = 0; end
            case (m_mode)
                M_SETUP, M_ENTER: begin
                    if (d_ev) m_digit = (m_digit + 1) % 10;
                    if (e_ev) begin
                        m_entry[m_cnt] = m_digit;
                        m_digit = 0;
                        m_cnt++;
                        if (m_cnt == DIGITS) begin
                            m_cnt = 0;
                            if (m_mode == M_SETUP) begin
                                m_pin = m_entry;
                                m_pin_set = 1;
                                m_mode = M_ENTER;
                            end else m_mode = M_CHECK;
                        end
                    end
                end
                M_CHECK: begin
                    same = 1;
                    for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_pin[i]) same = 0;
                    for (int i = 0; i < DIGITS; i++) m_entry[i] = 0;
                    if (same) begin
                        m_w = 1; m_fails = 0; m_mode = M_OPEN;
                    end else begin
                        m_fails++;
                        if (m_fails == MAX_TRIES) begin
                            m_left = LOCK_CYCLES; m_locked = 1; m_mode = M_LOCK;
                        end else m_mode = M_ENTER;
                    end
                end
                M_OPEN: if (lock_i) begin m_w = 0; m_mode = M_ENTER; end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_locked = 0; m_fails = 0; m_mode = M_ENTER; end
                end
            endcase
            esq_h[2] = esq_h[1]; esq_h[1] = esq_h[0]; esq_h[0] = b_esq_i;
            dir_h[2] = dir_h[1]; dir_h[1] = dir_h[0]; dir_h[0] = b_dir_i;
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("digit_o", int'(digit_o), m_digit);
            chk("digit_idx_o", int'(digit_idx_o), m_cnt);
            chk("pin_set_o", int'(pin_set_o), int'(m_pin_set));
            chk("w_o", int'(w_o), int'(m_w));
            chk("locked_o", int'(locked_o), int'(m_locked));
            chk("fail_cnt_o", int'(fail_cnt_o), m_fails);
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        b_esq_i = 0; b_dir_i = 0; lock_i = 0; rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic press(input bit esq, input bit dir, input int hold, input int gap);
        @(negedge clk_i);
        b_esq_i = esq; b_dir_i = dir;
        repeat (hold) @(negedge clk_i);
        b_esq_i = 0; b_dir_i = 0;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic digit_step(input int presses);
        for (int i = 0; i < presses; i++) press(0, 1, 3, 4);
        press(1, 0, 3, 4);
    endtask

    task automatic enter4(input int p0, input int p1, input int p2, input int p3);
        digit_step(p0); digit_step(p1); digit_step(p2); digit_step(p3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_digit"}, int'(digit_o), 0);
        chk({tag, "_idx"}, int'(digit_idx_o), 0);
        chk({tag, "_pin_set"}, int'(pin_set_o), 0);
        chk({tag, "_w"}, int'(w_o), 0);
        chk({tag, "_locked"}, int'(locked_o), 0);
        chk({tag, "_fail"}, int'(fail_cnt_o), 0);
    endtask

    task automatic random_phase(input int iters);
        int r;
        for (int k = 0; k < iters; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: press(0, 1, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
                4, 5:       press(1, 0, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
                6:          press(1, 1, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
                7: begin
                    @(negedge clk_i); lock_i = 1;
                    @(negedge clk_i); lock_i = 0;
                end
                8: repeat (int'($urandom_range(1, 6))) @(negedge clk_i);
                default: enter4(m_pin[0], m_pin[1], m_pin[2], m_pin[3]);
            endcase
        end
    endtask

    initial begin
        int n, t;

        // 1: three increments then a commit
        do_reset();
        check_all_zero("reset");
        press(0, 1, 3, 4); chk("p1_d1", int'(digit_o), 1);
        press(0, 1, 3, 4); chk("p1_d2", int'(digit_o), 2);
        press(0, 1, 3, 4); chk("p1_d3", int'(digit_o), 3);
        press(1, 0, 3, 4);
        chk("p1_commit_digit", int'(digit_o), 0);
        chk("p1_commit_idx", int'(digit_idx_o), 1);

        // 2: store PIN 2-0-9-1, second digit wraps through 10 presses
        do_reset();
        digit_step(2);
        for (int i = 0; i < 10; i++) press(0, 1, 3, 4);
        chk("p2_wrap", int'(digit_o), 0);
        press(1, 0, 3, 4);
        digit_step(9); digit_step(1);
        chk("p2_pin_set", int'(pin_set_o), 1);
        chk("p2_idx", int'(digit_idx_o), 0);

        // 3: correct entry unlocks, lock_i relocks
        enter4(2, 10, 9, 1);
        chk("p3_w", int'(w_o), 1);
        chk("p3_fail", int'(fail_cnt_o), 0);
        @(negedge clk_i); lock_i = 1;
        @(negedge clk_i); lock_i = 0;
        chk("p3_relock", int'(w_o), 0);

        // 4: three wrong entries, then timed lockout
        enter4(1, 1, 1, 1);
        chk("p4_fail1", int'(fail_cnt_o), 1);
        enter4(1, 1, 1, 1);
        chk("p4_fail2", int'(fail_cnt_o), 2);
        digit_step(1); digit_step(1); digit_step(1);
        press(0, 1, 3, 4);
        @(negedge clk_i); b_esq_i = 1;
        t = 0;
        while (!locked_o && t < 20) begin @(negedge clk_i); t++; end
        b_esq_i = 0;
        chk("p4_locked", int'(locked_o), 1);
        chk("p4_fail3", int'(fail_cnt_o), 3);
        n = 1;
        forever begin
            if (n == 5) b_dir_i = 1;
            if (n == 9) b_dir_i = 0;
            @(negedge clk_i);
            if (!locked_o || n >= 3 * LOCK_CYCLES) break;
            n++;
        end
        chk("p4_lock_len", n, LOCK_CYCLES);
        chk("p4_digit_frozen", int'(digit_o), 0);
        chk("p4_fail_clear", int'(fail_cnt_o), 0);

        // 5: simultaneous press is discarded, a long hold counts once
        press(1, 1, 3, 5);
        chk("p5_both_digit", int'(digit_o), 0);
        chk("p5_both_idx", int'(digit_idx_o), 0);
        press(0, 1, 20, 4);
        chk("p5_long_hold", int'(digit_o), 1);

        random_phase(400);

        // 6: reset mid-entry and while unlocked
        do_reset();
        digit_step(4); digit_step(5);
        do_reset();
        check_all_zero("rst_mid");
        enter4(3, 1, 4, 1);
        enter4(3, 1, 4, 1);
        chk("p6_unlocked", int'(w_o), 1);
        do_reset();
        check_all_zero("rst_open");

        random_phase(200);

        repeat (4) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
